// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem read address and
// registers the fetched word into the IF/ID pipeline register for decode.
//
// state | meaning
// WAIT  | first edge after reset release; nothing fetched yet
// RUN   | normal fetch with halt/flush/hold/jal/jalr priority
// HALT  | fetch stopped (break/trap or misaligned target); left only by reset
module fetch_stage #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
    parameter logic [31:0] NOP_INST   = 32'h0000_0033
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    output logic [31:0] o_imem_raddr,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_hold,
    input  logic        i_flush,
    input  logic [31:0] i_br_target,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic [31:0] i_dec_pc,
    input  logic [31:0] i_immediate,
    input  logic [31:0] i_jalr_rs1,
    input  logic        i_halt,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    output logic [31:0] o_nxt_pc,
    output logic        o_vld,
    output logic        o_misalign,
    output logic [31:0] o_fetch_cnt
);

    typedef enum logic [1:0] {
        S_WAIT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc_if_q, pc_if_d;
    logic [31:0] nxt_q, nxt_d;
    logic        vld_q, vld_d;
    logic        mis_q, mis_d;
    logic [31:0] cnt_q, cnt_d;

    logic [31:0] seq;
    logic [31:0] jal_tgt;
    logic [31:0] jalr_tgt;
    logic [31:0] redir_tgt;
    logic        redir;

    assign seq      = pc_q + 32'd4;
    assign jal_tgt  = i_dec_pc + i_immediate;
    assign jalr_tgt = (i_jalr_rs1 + i_immediate) & ~32'h1;

    // Flush beats hold; jal/jalr only count when decode is not stalled.
    assign redir     = i_flush || (!i_hold && (i_jal || i_jalr));
    assign redir_tgt = i_flush ? i_br_target : (i_jal ? jal_tgt : jalr_tgt);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        inst_d  = inst_q;
        pc_if_d = pc_if_q;
        nxt_d   = nxt_q;
        vld_d   = vld_q;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_WAIT: begin
                vld_d   = 1'b0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (i_halt) begin
                    state_d = S_HALT;
                    inst_d  = NOP_INST;
                    vld_d   = 1'b0;
                end else if (redir) begin
                    inst_d = NOP_INST;
                    vld_d  = 1'b0;
                    if (redir_tgt[1:0] != 2'b00) begin
                        mis_d   = 1'b1;
                        state_d = S_HALT;
                    end else begin
                        pc_d = redir_tgt;
                    end
                end else if (!i_hold) begin
                    pc_d    = seq;
                    inst_d  = i_imem_rdata;
                    pc_if_d = pc_q;
                    nxt_d   = seq;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_q + 32'd1;
                end
            end
            S_HALT: begin
                inst_d = NOP_INST;
                vld_d  = 1'b0;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_WAIT;
            pc_q    <= RESET_ADDR;
            inst_q  <= NOP_INST;
            pc_if_q <= 32'd0;
            nxt_q   <= 32'd0;
            vld_q   <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            inst_q  <= inst_d;
            pc_if_q <= pc_if_d;
            nxt_q   <= nxt_d;
            vld_q   <= vld_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_imem_raddr = pc_q;
    assign o_inst       = inst_q;
    assign o_pc         = pc_if_q;
    assign o_nxt_pc     = nxt_q;
    assign o_vld        = vld_q;
    assign o_misalign   = mis_q;
    assign o_fetch_cnt  = cnt_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: stimulus pushes expected IF/ID deliveries
// into a queue, a negedge monitor pops them whenever decode sees a new word.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'h0000_0033;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b1;
    logic [31:0] o_imem_raddr;
    logic [31:0] i_imem_rdata;
    logic        i_hold = 1'b0;
    logic        i_flush = 1'b0;
    logic [31:0] i_br_target = 32'd0;
    logic        i_jal = 1'b0;
    logic        i_jalr = 1'b0;
    logic [31:0] i_dec_pc = 32'd0;
    logic [31:0] i_immediate = 32'd0;
    logic [31:0] i_jalr_rs1 = 32'd0;
    logic        i_halt = 1'b0;
    logic [31:0] o_inst;
    logic [31:0] o_pc;
    logic [31:0] o_nxt_pc;
    logic        o_vld;
    logic        o_misalign;
    logic [31:0] o_fetch_cnt;

    fetch_stage #(.RESET_ADDR(32'h0000_0000), .NOP_INST(NOP)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .o_imem_raddr(o_imem_raddr), .i_imem_rdata(i_imem_rdata),
        .i_hold(i_hold), .i_flush(i_flush), .i_br_target(i_br_target),
        .i_jal(i_jal), .i_jalr(i_jalr), .i_dec_pc(i_dec_pc),
        .i_immediate(i_immediate), .i_jalr_rs1(i_jalr_rs1), .i_halt(i_halt),
        .o_inst(o_inst), .o_pc(o_pc), .o_nxt_pc(o_nxt_pc), .o_vld(o_vld),
        .o_misalign(o_misalign), .o_fetch_cnt(o_fetch_cnt)
    );

    always #5 i_clk = ~i_clk;

    // Instruction memory model: every word is its address tagged with A5A5.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction
    assign i_imem_rdata = mem_word(o_imem_raddr);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] nxt;
    } ifid_t;

    ifid_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cnt = 32'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc);
        ifid_t e;
        e.inst = mem_word(pc);
        e.pc   = pc;
        e.nxt  = pc + 32'd4;
        exp_q.push_back(e);
        exp_cnt = exp_cnt + 32'd1;
    endtask

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clr_in();
        i_hold = 0; i_flush = 0; i_jal = 0; i_jalr = 0; i_halt = 0;
    endtask

    task automatic restart();
        @(negedge i_clk);
        clr_in();
        i_rst_n = 1'b1;
        exp_cnt = 32'd0;
        step();
        chk("wait_vld", {31'd0, o_vld}, 32'd0);
        chk("wait_raddr", o_imem_raddr, 32'd0);
    endtask

    // Monitor: a new IF/ID word is any valid value differing from the last one seen.
    logic        last_vld = 1'b0;
    logic [31:0] last_pc = 32'd0;
    logic [31:0] last_inst = 32'd0;
    always @(negedge i_clk) begin
        if (o_vld && (!last_vld || o_pc != last_pc || o_inst != last_inst)) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ifid: got pc %08h inst %08h, none expected", o_pc, o_inst);
            end else begin
                ifid_t e;
                e = exp_q.pop_front();
                chk("ifid_inst", o_inst, e.inst);
                chk("ifid_pc", o_pc, e.pc);
                chk("ifid_nxt", o_nxt_pc, e.nxt);
            end
        end
        last_vld  = o_vld;
        last_pc   = o_pc;
        last_inst = o_inst;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2 i_rst_n = 1'b0;
        #1;
        chk("rst_vld", {31'd0, o_vld}, 32'd0);
        chk("rst_inst", o_inst, NOP);
        chk("rst_pc", o_pc, 32'd0);
        chk("rst_nxt", o_nxt_pc, 32'd0);
        chk("rst_raddr", o_imem_raddr, 32'd0);
        chk("rst_mis", {31'd0, o_misalign}, 32'd0);
        chk("rst_cnt", o_fetch_cnt, 32'd0);

        restart();
        push(32'h0); step();
        push(32'h4); step();
        chk("seq_cnt", o_fetch_cnt, 32'd2);
        chk("seq_raddr", o_imem_raddr, 32'h8);

        // hold freezes PC and IF/ID
        i_hold = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_raddr", o_imem_raddr, 32'h8);
            chk("hold_pc", o_pc, 32'h4);
            chk("hold_cnt", o_fetch_cnt, exp_cnt);
        end
        i_hold = 0;
        push(32'h8); step();
        chk("rel_cnt", o_fetch_cnt, exp_cnt);

        // jal: target = 4 + 0x20
        i_jal = 1; i_dec_pc = 32'h4; i_immediate = 32'h20;
        step();
        i_jal = 0;
        chk("jal_vld", {31'd0, o_vld}, 32'd0);
        chk("jal_raddr", o_imem_raddr, 32'h24);
        push(32'h24); step();

        // jalr: (0x101 + 0x10) & ~1 = 0x110
        i_jalr = 1; i_jalr_rs1 = 32'h101; i_immediate = 32'h10;
        step();
        chk("jalr_raddr", o_imem_raddr, 32'h110);
        chk("jalr_vld", {31'd0, o_vld}, 32'd0);
        i_flush = 1; i_br_target = 32'h40;
        step();
        i_jalr = 0; i_flush = 0;
        chk("flush_jalr_raddr", o_imem_raddr, 32'h40);
        push(32'h40); step();

        // flush beats hold
        i_hold = 1; i_flush = 1; i_br_target = 32'h80;
        step();
        i_hold = 0; i_flush = 0;
        chk("flush_hold_raddr", o_imem_raddr, 32'h80);
        chk("flush_hold_vld", {31'd0, o_vld}, 32'd0);
        push(32'h80); step();

        // jal ignored under hold
        i_hold = 1; i_jal = 1; i_dec_pc = 32'h200; i_immediate = 32'h0;
        step();
        i_hold = 0; i_jal = 0;
        chk("hold_jal_raddr", o_imem_raddr, 32'h84);
        chk("hold_jal_vld", {31'd0, o_vld}, 32'd1);
        push(32'h84); step();

        // jal wins over jalr
        i_jal = 1; i_jalr = 1; i_dec_pc = 32'h100; i_immediate = 32'h4; i_jalr_rs1 = 32'h200;
        step();
        i_jal = 0; i_jalr = 0;
        chk("jal_prio_raddr", o_imem_raddr, 32'h104);

        // wrap at top of address space
        i_flush = 1; i_br_target = 32'hFFFF_FFFC;
        step();
        i_flush = 0;
        chk("wrap_raddr0", o_imem_raddr, 32'hFFFF_FFFC);
        push(32'hFFFF_FFFC); step();
        chk("wrap_raddr1", o_imem_raddr, 32'h0);
        chk("wrap_nxt", o_nxt_pc, 32'h0);
        push(32'h0); step();
        chk("wrap_cnt", o_fetch_cnt, exp_cnt);

        // halt is sticky
        i_halt = 1;
        step();
        i_halt = 0;
        chk("halt_vld", {31'd0, o_vld}, 32'd0);
        chk("halt_inst", o_inst, NOP);
        chk("halt_raddr", o_imem_raddr, 32'h4);
        step(); step();
        chk("halt_raddr2", o_imem_raddr, 32'h4);
        chk("halt_vld2", {31'd0, o_vld}, 32'd0);
        chk("halt_cnt", o_fetch_cnt, exp_cnt);
        #2 i_rst_n = 1'b0;
        #1;
        chk("halt_rst_raddr", o_imem_raddr, 32'h0);
        chk("halt_rst_cnt", o_fetch_cnt, 32'd0);

        // misaligned branch target
        restart();
        push(32'h0); step();
        push(32'h4); step();
        i_flush = 1; i_br_target = 32'h42;
        step();
        i_flush = 0;
        chk("mis_flag", {31'd0, o_misalign}, 32'd1);
        chk("mis_vld", {31'd0, o_vld}, 32'd0);
        chk("mis_raddr", o_imem_raddr, 32'h8);
        step(); step();
        chk("mis_raddr2", o_imem_raddr, 32'h8);
        chk("mis_vld2", {31'd0, o_vld}, 32'd0);
        chk("mis_cnt", o_fetch_cnt, 32'd2);
        #2 i_rst_n = 1'b0;
        #1;
        chk("mis_rst_flag", {31'd0, o_misalign}, 32'd0);

        // misaligned jal target 0 + 6
        restart();
        push(32'h0); step();
        i_jal = 1; i_dec_pc = 32'h0; i_immediate = 32'h6;
        step();
        i_jal = 0;
        chk("mis_jal_flag", {31'd0, o_misalign}, 32'd1);
        chk("mis_jal_raddr", o_imem_raddr, 32'h4);
        step();
        chk("mis_jal_vld", {31'd0, o_vld}, 32'd0);
        #2 i_rst_n = 1'b0;
        #1;
        chk("final_rst_mis", {31'd0, o_misalign}, 32'd0);
        chk("final_rst_raddr", o_imem_raddr, 32'h0);
        chk("final_rst_vld", {31'd0, o_vld}, 32'd0);

        step(); step();
        chk("queue_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
